// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and default constants for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_RELEASE   = 2'd1,
        ST_RUN       = 2'd2
    } rst_state_t;

    localparam int DEF_N_STAGES     = 3;
    localparam int DEF_STAGE_DLY    = 4;
    localparam int DEF_LOCK_FILT    = 3;
    localparam int DEF_LOCK_TIMEOUT = 1024;

endpackage

// File: rtl/rst_seq_sync.sv
// rtl/rst_seq_sync.sv - two-flop synchronizer bringing the PLL lock into the i_clk domain
module rst_seq_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic async_in,
    output logic sync_out
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged reset release after filtered PLL lock; RST_SEQ_WDT_EN adds the lock-timeout watchdog
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_STAGES     = DEF_N_STAGES,
    parameter int STAGE_DLY    = DEF_STAGE_DLY,
    parameter int LOCK_FILT    = DEF_LOCK_FILT,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_pll_locked,
    input  logic                i_sw_rst,
    output logic [N_STAGES-1:0] o_rst_n,
    output logic                o_ready,
    output logic                o_lock_timeout
);

    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    logic                lock_s;
    logic                abort;
    rst_state_t          state;
    logic [7:0]          filt_cnt;
    logic [15:0]         dly_cnt;
    logic [IDX_W-1:0]    stage_idx;
    logic [N_STAGES-1:0] rst_q;
    logic                ready_q;

    rst_seq_sync u_sync (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .async_in (i_pll_locked),
        .sync_out (lock_s)
    );

    assign abort = !lock_s || i_sw_rst;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_WAIT_LOCK;
            filt_cnt  <= '0;
            dly_cnt   <= '0;
            stage_idx <= '0;
            rst_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    dly_cnt   <= '0;
                    stage_idx <= '0;
                    if (abort) begin
                        filt_cnt <= '0;
                    end else if (filt_cnt == 8'(LOCK_FILT - 1)) begin
                        filt_cnt <= '0;
                        state    <= ST_RELEASE;
                    end else begin
                        filt_cnt <= filt_cnt + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    if (abort) begin
                        state     <= ST_WAIT_LOCK;
                        filt_cnt  <= '0;
                        dly_cnt   <= '0;
                        stage_idx <= '0;
                        rst_q     <= '0;
                        ready_q   <= 1'b0;
                    end else if (dly_cnt == 16'(STAGE_DLY - 1)) begin
                        // Stages release strictly in index order, keeping rst_q thermometer-coded.
                        rst_q[stage_idx] <= 1'b1;
                        dly_cnt          <= '0;
                        if (stage_idx == IDX_W'(N_STAGES - 1)) begin
                            state   <= ST_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            stage_idx <= stage_idx + 1'b1;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 16'd1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state     <= ST_WAIT_LOCK;
                        filt_cnt  <= '0;
                        dly_cnt   <= '0;
                        stage_idx <= '0;
                        rst_q     <= '0;
                        ready_q   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_WAIT_LOCK;
                    filt_cnt  <= '0;
                    dly_cnt   <= '0;
                    stage_idx <= '0;
                    rst_q     <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_rst_n = rst_q;
    assign o_ready = ready_q;

`ifdef RST_SEQ_WDT_EN
    logic [31:0] wdt_cnt;
    logic        timeout_q;

    // Flag is sticky until the hard reset; sequencing is never blocked by it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdt_cnt   <= '0;
            timeout_q <= 1'b0;
        end else if (state != ST_WAIT_LOCK) begin
            wdt_cnt <= '0;
        end else if (wdt_cnt == 32'(LOCK_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
        end else begin
            wdt_cnt <= wdt_cnt + 32'd1;
        end
    end

    assign o_lock_timeout = timeout_q;
`else
    assign o_lock_timeout = 1'b0;
`endif

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter N_STAGES, default 3: number of staged reset outputs, range 1..8.
REQ-002 SHALL have parameter STAGE_DLY, default 4: cycles between successive stage releases, range 1..65535.
REQ-003 SHALL have parameter LOCK_FILT, default 3: consecutive synchronized-lock-high cycles required to qualify lock, range 1..255.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 1024: cycles allowed in WAIT_LOCK before timeout; used only under RST_SEQ_WDT_EN.
REQ-005 SHALL have port i_clk, input, 1: clock.
REQ-006 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port i_pll_locked, input, 1: PLL lock, asynchronous to i_clk.
REQ-008 SHALL have port i_sw_rst, input, 1: synchronous software reset request, level-sensitive.
REQ-009 SHALL have port o_rst_n, output, N_STAGES: staged active-low resets; bit 0 releases first.
REQ-010 SHALL have port o_ready, output, 1: high only in RUN.
REQ-011 SHALL have port o_lock_timeout, output, 1: sticky lock-timeout flag.

Function
REQ-012 SHALL synchronize i_pll_locked through 2 flops; "lock_s" denotes the synchronizer output.
REQ-013 SHALL implement states WAIT_LOCK, RELEASE, RUN; reset state WAIT_LOCK.
REQ-014 In WAIT_LOCK, a filter counter SHALL increment while lock_s=1 and clear when lock_s=0; at LOCK_FILT consecutive ones, next state RELEASE, stage index=0, delay counter=0.
REQ-015 In RELEASE, the delay counter SHALL increment each cycle; when it equals STAGE_DLY-1, o_rst_n[index] SHALL go high on the next edge, the counter SHALL clear, and the index SHALL increment.
REQ-016 The first stage SHALL release STAGE_DLY cycles after entering RELEASE; stage k SHALL release (k+1)*STAGE_DLY cycles after entering RELEASE.
REQ-017 When the last stage releases, the FSM SHALL enter RUN and assert o_ready on the same edge.
REQ-018 Released stages SHALL stay high; o_rst_n SHALL be thermometer-coded (bit k high implies all bits below k high) at all times.
REQ-019 lock_s=0 or i_sw_rst=1 in RELEASE or RUN SHALL, on the next edge, drive all o_rst_n low, deassert o_ready, clear counters, and enter WAIT_LOCK.
REQ-020 i_sw_rst=1 in WAIT_LOCK SHALL hold the filter counter at 0; sequencing SHALL resume only after i_sw_rst=0.
REQ-021 When i_sw_rst and lock-loss coincide, behaviour SHALL equal either alone (REQ-019).
REQ-022 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-023 While i_rst_n=0: o_rst_n=all zeros, o_ready=0, o_lock_timeout=0, synchronizer and counters cleared, state WAIT_LOCK, asynchronously.
REQ-024 Deassertion of i_rst_n SHALL restart sequencing from WAIT_LOCK regardless of the prior state (mid-RELEASE included).

Configuration
REQ-025 With RST_SEQ_WDT_EN defined: a timeout counter SHALL run in WAIT_LOCK, clear on leaving it, and on reaching LOCK_TIMEOUT SHALL set o_lock_timeout, which SHALL remain set until i_rst_n=0; sequencing SHALL continue normally.
REQ-026 Without RST_SEQ_WDT_EN: no timeout counter SHALL exist, o_lock_timeout SHALL be tied 0, and LOCK_TIMEOUT SHALL be ignored.

Structure
REQ-027 State encoding typedef and the default constants (N_STAGES, STAGE_DLY, LOCK_FILT, LOCK_TIMEOUT) SHALL reside in shared package rst_seq_pkg.
REQ-028 The 2-flop lock synchronizer SHALL be sub-module rst_seq_sync (ASYNC_REG on its flops); the FSM and counters SHALL stay in rst_sequencer.

Verification (defaults N_STAGES=3, STAGE_DLY=4, LOCK_FILT=3)
REQ-029 Lock high from cycle 0 after reset -> lock_s at cycle 2; RELEASE entered at cycle 5; o_rst_n = 001 at cycle 9, 011 at 13, 111 at 17; o_ready=1 at 17.
REQ-030 Lock glitch: high 2 cycles, low 1, then steady -> filter restarts; RELEASE is entered only after 3 consecutive lock_s ones.
REQ-031 Lock drop while o_rst_n=011 -> o_rst_n=000 and WAIT_LOCK one edge after lock_s falls; full sequence repeats on relock.
REQ-032 i_sw_rst pulsed 1 cycle in RUN -> o_rst_n=000 and o_ready=0 next edge; full re-sequence follows with lock held steady.
REQ-033 i_rst_n asserted mid-RELEASE -> all outputs 0 immediately (asynchronously); after release, timing matches REQ-029.
REQ-034 RST_SEQ_WDT_EN, LOCK_TIMEOUT=16, lock held low -> o_lock_timeout=1 after 16 cycles in WAIT_LOCK; it stays 1 after later lock and RUN until i_rst_n=0.
